// File: rtl/input_cond_pkg.sv
// Shared types, default parameters and counter-width helpers for input_conditioner.
package input_cond_pkg;

    localparam int DEF_NUM_SW          = 7;
    localparam int DEF_NUM_BTN         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LONG_CYCLES     = 1000;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } ch_out_t;

    // Debounce counter holds 0..n-1; kept at least one bit wide for n=1.
    function automatic int db_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Hold counter must reach n itself, hence n+1 states.
    function automatic int hold_cnt_w(input int n);
        return (n <= 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// Single-channel two-flop synchroniser and debouncer with registered level/rise/fall.
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    raw,
    output ch_out_t ch
);

    localparam int CW = db_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          level_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the stable value restarts the run.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == C_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Output stage: edges are detected against the previous registered level.
            level_q <= stable;
            rise_q  <= stable & ~level_q;
            fall_q  <= ~stable & level_q;
        end
    end

    assign ch = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/input_conditioner.sv
// Switch/button front end: per-channel debounce, button inversion, optional long-press.
// Long-press detection is built only when INPUT_COND_LONGPRESS_EN is defined.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int NUM_SW          = DEF_NUM_SW,
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_n_in,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_SW-1:0]  sw_change,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    ch_out_t sw_ch  [NUM_SW];
    ch_out_t btn_ch [NUM_BTN];

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_in[i]),
            .ch    (sw_ch[i])
        );
        assign sw_level[i]  = sw_ch[i].level;
        assign sw_change[i] = sw_ch[i].rise | sw_ch[i].fall;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (~btn_n_in[i]),
            .ch    (btn_ch[i])
        );
        assign btn_level[i]   = btn_ch[i].level;
        assign btn_press[i]   = btn_ch[i].rise;
        assign btn_release[i] = btn_ch[i].fall;

`ifdef INPUT_COND_LONGPRESS_EN
        localparam int HW = hold_cnt_w(LONG_CYCLES);
        localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

        logic [HW-1:0] hold_cnt;
        logic          long_q;

        // Saturating at HOLD_MAX guarantees a single pulse per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else if (btn_ch[i].level) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                long_q <= (hold_cnt == HOLD_MAX - 1'b1);
            end else begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end
        end

        assign btn_long[i] = long_q;
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
module tb_input_conditioner;

    localparam int NSW  = 7;
    localparam int NBTN = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;
`ifdef INPUT_COND_LONGPRESS_EN
    localparam logic LONG_EXP = 1'b1;
`else
    localparam logic LONG_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSW-1:0]  sw_in;
    logic [NBTN-1:0] btn_n_in;
    logic [NSW-1:0]  sw_level, sw_change;
    logic [NBTN-1:0] btn_level, btn_press, btn_release, btn_long;

    int tests = 0;
    int fails = 0;

    input_conditioner #(
        .NUM_SW(NSW), .NUM_BTN(NBTN), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .btn_n_in    (btn_n_in),
        .sw_level    (sw_level),
        .sw_change   (sw_change),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [NSW-1:0]  sw_acc;
    logic [NBTN-1:0] btn_acc, both_acc;
    int              long_cnt;

    initial begin
        // Reset with arbitrary inputs
        rst_n    = 1'b0;
        sw_in    = 7'h55;
        btn_n_in = 2'b01;
        ticks(4);
        chk("rst_sw_level",  sw_level,    0);
        chk("rst_sw_change", sw_change,   0);
        chk("rst_btn_level", btn_level,   0);
        chk("rst_btn_pulse", {btn_press, btn_release, btn_long}, 0);

        // Release reset with sw[0] held high; edge 0 is the first edge after release
        sw_in    = 7'h01;
        btn_n_in = 2'b11;
        rst_n    = 1'b1;
        ticks(6);
        chk("rst_rel_e5_level", sw_level, 0);
        tick();
        chk("rst_rel_e6_level",  sw_level,  7'h01);
        chk("rst_rel_e6_change", sw_change, 7'h01);
        tick();
        chk("rst_rel_e7_change", sw_change, 0);

        // Clean press of button 1
        btn_n_in = 2'b01;
        ticks(6);
        chk("press_e5_level", btn_level, 0);
        tick();
        chk("press_e6_level", btn_level,   2'b10);
        chk("press_e6_press", btn_press,   2'b10);
        chk("press_e6_rel",   btn_release, 0);
        tick();
        chk("press_e7_press", btn_press, 0);
        ticks(3);
        btn_n_in = 2'b11;
        ticks(6);
        chk("rel_e5_rel", btn_release, 0);
        tick();
        chk("rel_e6_rel",   btn_release, 2'b10);
        chk("rel_e6_level", btn_level,   0);
        chk("rel_e6_press", btn_press,   0);
        tick();
        chk("rel_e7_rel", btn_release, 0);

        // Bounce on sw[3]: runs of 2 are never accepted
        sw_acc = '0;
        for (int b = 0; b < 4; b++) begin
            sw_in[3] = ~b[0];
            for (int k = 0; k < 2; k++) begin
                tick();
                sw_acc |= sw_change;
            end
        end
        sw_in[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            sw_acc |= sw_change;
        end
        chk("bounce_quiet", sw_acc, 0);
        tick();
        chk("bounce_e6_change", sw_change, 7'h08);
        chk("bounce_e6_level",  sw_level,  7'h09);
        tick();
        chk("bounce_e7_change", sw_change, 0);

        // Everything toggles on the same edge
        sw_in    = 7'h76;
        btn_n_in = 2'b00;
        both_acc = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            both_acc |= btn_press & btn_release;
        end
        tick();
        chk("simul_sw_change", sw_change,   7'h7F);
        chk("simul_sw_level",  sw_level,    7'h76);
        chk("simul_press",     btn_press,   2'b11);
        chk("simul_rel",       btn_release, 0);
        ticks(2);
        sw_in    = 7'h09;
        btn_n_in = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            both_acc |= btn_press & btn_release;
        end
        tick();
        chk("simul2_sw_change", sw_change,   7'h7F);
        chk("simul2_rel",       btn_release, 2'b11);
        chk("simul2_press",     btn_press,   0);
        chk("simul_exclusive",  both_acc,    0);
        ticks(2);

        // Reset three cycles into a press of button 0
        btn_n_in = 2'b10;
        btn_acc  = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            btn_acc |= btn_press;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_no_press", btn_acc, 0);
        chk("midrst_levels",   {sw_level, btn_level}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        ticks(6);
        chk("midrst_e5_level", btn_level, 0);
        tick();
        chk("midrst_e6_level", btn_level, 2'b01);
        chk("midrst_e6_press", btn_press, 2'b01);
        chk("midrst_e6_sw",    sw_level,  7'h09);

        // Long press: keep button 0 held for 30 more cycles
        long_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (btn_long[0]) long_cnt++;
            if (k == LONG - 1) chk("long_before", btn_long, 0);
            if (k == LONG)     chk("long_at",     btn_long, {1'b0, LONG_EXP});
        end
        chk("long_count", long_cnt, LONG_EXP ? 1 : 0);
        chk("long_held_level", btn_level, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
